imem_ctrl: RTL and testbench

//  Controller for a single-port, synchronous instruction RAM that replaces the hardcoded ROM.
//  It loads a program from a word stream while the CPU is held, then runs the CPU.
//  The one RAM port is shared between CPU fetch and a debug read port.

---
 rtl/imem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_imem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// ============================================================================
// Module      : imem_ctrl
// Description : Instruction RAM controller. It loads a program from a word
//               stream while holding the CPU, then arbitrates the single RAM
//               port between CPU fetch and debug reads.
//               Build option IMEM_CTRL_BOOTROM_EN: reset enters the run state
//               directly, and the RAM model is expected to be preloaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_ctrl #(
    parameter int DEPTH       = 64,
    parameter int AW          = 6,
    parameter int DBG_MAXWAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          cpu_hold,
    input  logic          cpu_req,
    input  logic [31:0]   cpu_addr,
    output logic          cpu_stall,
    output logic          cpu_valid,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_gnt,
    output logic          dbg_valid,
    output logic [31:0]   dbg_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int WW = $clog2(DBG_MAXWAIT + 1);
    localparam logic [WW-1:0] C_WAIT_MAX   = WW'(DBG_MAXWAIT);
    localparam logic [WW-1:0] C_WAIT_FORCE = WW'(DBG_MAXWAIT - 1);
    localparam logic [AW-1:0] C_LAST_PTR   = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

`ifdef IMEM_CTRL_BOOTROM_EN
    localparam state_t C_RST_STATE = S_RUN;
    localparam logic   C_RST_HOLD  = 1'b0;
`else
    localparam state_t C_RST_STATE = S_HOLD;
    localparam logic   C_RST_HOLD  = 1'b1;
`endif

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [WW-1:0] r_wait;
    logic          r_cpu_hold;
    logic          r_cpu_valid;
    logic          r_cpu_err;
    logic          r_dbg_valid;

    logic          w_run;
    logic          w_load;
    logic          w_cpu_oor;
    logic          w_force;
    logic          w_dbg_gnt;
    logic          w_cpu_gnt;
    logic          w_ld_wr;
    logic          w_unused;

    // Byte-offset bits carry no information for word fetches.
    assign w_unused = ^cpu_addr[1:0];

    always_comb begin
        w_run     = (r_state == S_RUN);
        w_load    = (r_state == S_LOAD);
        w_cpu_oor = |cpu_addr[31:AW+2];
        // Forced on the DBG_MAXWAIT-th waiting cycle: the counter holds the
        // number of cycles already lost, so this cycle would be the last one.
        w_force   = dbg_req && (r_wait == C_WAIT_FORCE);
        w_dbg_gnt = w_run && dbg_req && (!cpu_req || w_force);
        w_cpu_gnt = w_run && cpu_req && !w_dbg_gnt;
        w_ld_wr   = w_load && ld_valid && !ld_start;
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_ld_wr) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = r_ptr;
            ram_wdata = ld_data;
        end else if (w_dbg_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = dbg_addr;
        end else if (w_cpu_gnt && !w_cpu_oor) begin
            ram_en    = 1'b1;
            ram_addr  = cpu_addr[AW+1:2];
        end
    end

    assign ld_ready  = w_load && !ld_start;
    assign cpu_hold  = r_cpu_hold;
    assign cpu_stall = cpu_req && !w_cpu_gnt;
    assign dbg_gnt   = w_dbg_gnt;
    assign cpu_valid = r_cpu_valid;
    assign cpu_err   = r_cpu_err;
    assign dbg_valid = r_dbg_valid;
    // RAM data arrives one cycle after the grant; gate it so idle cycles read 0.
    assign cpu_rdata = (r_cpu_valid && !r_cpu_err) ? ram_rdata : 32'd0;
    assign dbg_rdata = r_dbg_valid ? ram_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= C_RST_STATE;
            r_cpu_hold  <= C_RST_HOLD;
            r_ptr       <= '0;
            r_wait      <= '0;
            r_cpu_valid <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dbg_valid <= 1'b0;
        end else begin
            r_cpu_valid <= w_cpu_gnt;
            r_cpu_err   <= w_cpu_gnt && w_cpu_oor;
            r_dbg_valid <= w_dbg_gnt;

            if (w_dbg_gnt) begin
                r_wait <= '0;
            end else if (w_run && dbg_req && (r_wait != C_WAIT_MAX)) begin
                r_wait <= r_wait + 1'b1;
            end

            case (r_state)
                S_HOLD: begin
                    if (ld_start) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_start) begin
                        r_ptr <= '0;
                    end else if (ld_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (ld_last || (r_ptr == C_LAST_PTR)) begin
                            r_state    <= S_RUN;
                            r_cpu_hold <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (ld_start) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_HOLD;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_ctrl.sv
// ============================================================================
// Module      : tb_imem_ctrl
// Description : Directed bench for imem_ctrl with a behavioural sync RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

`ifdef IMEM_CTRL_BOOTROM_EN
    localparam logic C_HOLD_RST = 1'b0;
`else
    localparam logic C_HOLD_RST = 1'b1;
`endif

    logic          clk;
    logic          reset;
    logic          ld_start;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          cpu_hold;
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic          cpu_stall;
    logic          cpu_valid;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_valid;
    logic [31:0]   dbg_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    imem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DBG_MAXWAIT(8)) dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .cpu_hold(cpu_hold),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
        .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ram_rdata = 32'd0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ld_start = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
        cpu_req = 0; cpu_addr = 0; dbg_req = 0; dbg_addr = 0;
        tick(); tick();
        #1;
        chk("rst_hold",  cpu_hold,  C_HOLD_RST);
        chk("rst_ready", ld_ready,  0);
        chk("rst_ramen", ram_en,    0);
        chk("rst_valid", cpu_valid, 0);
        chk("rst_gnt",   dbg_gnt,   0);
        reset = 1'b1;
        tick();

        // Load A0..A3
        ld_start = 1; tick(); ld_start = 0;
        cpu_req = 1;
        #1;
        chk("ld_ready", ld_ready, 1);
        chk("ld_hold_stall", cpu_stall, 1);
        chk("ld_hold_gnt", dbg_gnt, 0);
        cpu_req = 0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = 32'hA000_0000 | i; ld_last = (i == 3);
            #1;
            chk("ld_we",    ram_we,    1);
            chk("ld_addr",  ram_addr,  i);
            chk("ld_wdata", ram_wdata, 32'hA000_0000 | i);
            chk("ld_hold",  cpu_hold,  1);
            tick();
        end
        ld_valid = 0; ld_last = 0;
        #1;
        chk("run_hold", cpu_hold, 0);

        // Back-to-back fetches
        cpu_req = 1; cpu_addr = 32'h0;
        #1;
        chk("f0_stall", cpu_stall, 0);
        chk("f0_addr",  ram_addr,  0);
        tick(); cpu_addr = 32'h4;
        #1;
        chk("f0_valid", cpu_valid, 1);
        chk("f0_data",  cpu_rdata, 32'hA000_0000);
        chk("f1_stall", cpu_stall, 0);
        tick(); cpu_addr = 32'h8;
        #1;
        chk("f1_data",  cpu_rdata, 32'hA000_0001);
        tick(); cpu_req = 0;
        #1;
        chk("f2_data",  cpu_rdata, 32'hA000_0002);
        chk("f2_err",   cpu_err,   0);
        tick();
        chk("f_idle",   cpu_valid, 0);

        // Starvation: forced debug grant on the 8th waiting cycle
        cpu_req = 1; cpu_addr = 32'h0; dbg_req = 1; dbg_addr = 6'd2;
        for (int k = 1; k < 8; k++) begin
            #1;
            chk("st_nogrant", dbg_gnt,   0);
            chk("st_cpu",     cpu_stall, 0);
            tick();
        end
        #1;
        chk("st_gnt",   dbg_gnt,   1);
        chk("st_stall", cpu_stall, 1);
        chk("st_addr",  ram_addr,  2);
        tick(); dbg_req = 0;
        #1;
        chk("st_dvalid", dbg_valid, 1);
        chk("st_ddata",  dbg_rdata, 32'hA000_0002);
        chk("st_cvalid", cpu_valid, 0);
        chk("st_after",  cpu_stall, 0);
        tick();
        chk("st_cdata",  cpu_rdata, 32'hA000_0000);

        // Debug read while CPU idle, granted immediately
        cpu_req = 0; dbg_req = 1; dbg_addr = 6'd1;
        #1;
        chk("dbg_gnt", dbg_gnt, 1);
        tick(); dbg_req = 0;
        #1;
        chk("dbg_data", dbg_rdata, 32'hA000_0001);

        // Out of range fetch, then unaligned fetch
        cpu_req = 1; cpu_addr = 32'h100;
        #1;
        chk("oor_ramen", ram_en,    0);
        chk("oor_stall", cpu_stall, 0);
        tick(); cpu_addr = 32'hD;
        #1;
        chk("oor_valid", cpu_valid, 1);
        chk("oor_err",   cpu_err,   1);
        chk("oor_data",  cpu_rdata, 0);
        tick(); cpu_req = 0;
        #1;
        chk("ua_err",  cpu_err,   0);
        chk("ua_data", cpu_rdata, 32'hA000_0003);
        tick();

        // Full 64-word load without ld_last, reloaded from run state
        ld_start = 1; tick(); ld_start = 0;
        #1;
        chk("fl_hold", cpu_hold, 1);
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1; ld_data = 32'hB000_0000 | i;
            tick();
        end
        #1;
        chk("fl_hold_lo", cpu_hold, 0);
        chk("fl_ready",   ld_ready, 0);
        chk("fl_ramen",   ram_en,   0);
        ld_valid = 0;
        cpu_req = 1; cpu_addr = 32'hFC;
        tick(); cpu_addr = 32'h0;
        #1;
        chk("fl_last", cpu_rdata, 32'hB000_003F);
        tick(); cpu_req = 0;
        #1;
        chk("fl_first", cpu_rdata, 32'hB000_0000);
        tick();

        // Reset in the middle of a load
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1; ld_data = 32'hC000_0000 | i;
            tick();
        end
        ld_valid = 0;
        reset = 0;
        #1;
        chk("mr_hold",  cpu_hold, C_HOLD_RST);
        chk("mr_ready", ld_ready, 0);
        chk("mr_ramen", ram_en,   0);
        tick();
        reset = 1;
        tick();
        ld_valid = 1; ld_data = 32'hDEAD_BEEF;
        #1;
        chk("mr_ignore", ram_en,   0);
        chk("mr_hold2",  cpu_hold, C_HOLD_RST);
        ld_valid = 0;
        tick();
        chk("mr_mem0", mem[0], 32'hC000_0000);
        chk("mr_mem2", mem[2], 32'hB000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
